vp_pixels_to_bitmap: RTL

Two-colour block encoder for the video pipeline. It takes one 64-bit word of 16 packed 4-bit pixels and produces a 16-bit bitmap plus foreground and background colour indices. It is the inverse of the bitmap-to-pixels expander and sits on the capture/compose path ahead of character-cell storage. Pixels are scanned LANES at a time over several cycles, with valid/ready handshakes on both sides.

---
 rtl/vp_pixels_to_bitmap.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/vp_pixels_to_bitmap.sv
// vp_pixels_to_bitmap: two-colour block encoder.
// Converts one 64-bit word of 16 packed 4-bit pixels (pixel i = in_pixels[63-4i -: 4])
// into a 16-bit bitmap plus foreground/background colour indices, scanning LANES
// pixels per cycle. Background is pixel 0's colour; the foreground is the first
// pixel that differs from it. out_lossy flags words with more than two colours.
// Optional macro VP_P2B_MAJORITY_BG_EN adds a SWAP cycle that makes the
// background the majority colour (strictly more than 8 foreground pixels).
module vp_pixels_to_bitmap #(
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_pixels,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_bitmap,
  output logic [3:0]  out_foreground,
  output logic [3:0]  out_background,
  output logic        out_lossy,
  output logic        out_valid,
  input  logic        out_ready
);

  // Only divisors of 16 give a whole number of scan groups.
  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("vp_pixels_to_bitmap: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam int          NGROUPS    = 16 / LANES;
  localparam logic [3:0]  LAST_GROUP = 4'(NGROUPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
`ifdef VP_P2B_MAJORITY_BG_EN
    , S_SWAP = 2'd3
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [63:0] r_pixels;
  logic [15:0] r_bitmap;
  logic [3:0]  r_fg;
  logic [3:0]  r_bg;
  logic        r_fg_found;
  logic        r_lossy;
  logic [3:0]  r_group;

  logic [15:0] r_out_bitmap;
  logic [3:0]  r_out_fg;
  logic [3:0]  r_out_bg;
  logic        r_out_lossy;

  logic [3:0]  w_pix [16];
  logic [15:0] w_bitmap;
  logic [3:0]  w_fg;
  logic        w_fg_found;
  logic        w_lossy;
  logic [3:0]  w_idx;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

`ifdef VP_P2B_MAJORITY_BG_EN
  logic w_do_swap;
  assign w_do_swap = r_fg_found && (popcount16(r_bitmap) > 5'd8);
`endif

  assign out_bitmap     = r_out_bitmap;
  assign out_foreground = r_out_fg;
  assign out_background = r_out_bg;
  assign out_lossy      = r_out_lossy;

  // Unpack the latched word into per-pixel colours, pixel 0 in the top nibble.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_pix[i] = r_pixels[63 - 4*i -: 4];
    end
  end

  // Classify the current group's pixels in ascending index order.
  always_comb begin
    w_bitmap   = r_bitmap;
    w_fg       = r_fg;
    w_fg_found = r_fg_found;
    w_lossy    = r_lossy;
    w_idx      = 4'd0;
    for (int l = 0; l < LANES; l++) begin
      w_idx = 4'(int'(r_group) * LANES + l);
      if (w_pix[w_idx] == r_bg) begin
        w_bitmap[w_idx] = 1'b0;
      end else begin
        w_bitmap[w_idx] = 1'b1;
        if (!w_fg_found) begin
          w_fg       = w_pix[w_idx];
          w_fg_found = 1'b1;
        end else if (w_pix[w_idx] != w_fg) begin
          w_lossy = 1'b1;
        end else begin
          w_lossy = w_lossy;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_SCAN;
        else          w_next = S_IDLE;
      end
      S_SCAN: begin
        if (r_group == LAST_GROUP) begin
`ifdef VP_P2B_MAJORITY_BG_EN
          w_next = S_SWAP;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_SCAN;
        end
      end
`ifdef VP_P2B_MAJORITY_BG_EN
      S_SWAP: begin
        w_next = S_DONE;
      end
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
        else           w_next = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Working registers and result registers; results hold until the next word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixels     <= 64'd0;
      r_bitmap     <= 16'd0;
      r_fg         <= 4'd0;
      r_bg         <= 4'd0;
      r_fg_found   <= 1'b0;
      r_lossy      <= 1'b0;
      r_group      <= 4'd0;
      r_out_bitmap <= 16'd0;
      r_out_fg     <= 4'd0;
      r_out_bg     <= 4'd0;
      r_out_lossy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_pixels   <= in_pixels;
            r_bg       <= in_pixels[63:60];
            r_fg       <= 4'd0;
            r_fg_found <= 1'b0;
            r_lossy    <= 1'b0;
            r_bitmap   <= 16'd0;
            r_group    <= 4'd0;
          end
        end
        S_SCAN: begin
          r_bitmap   <= w_bitmap;
          r_fg       <= w_fg;
          r_fg_found <= w_fg_found;
          r_lossy    <= w_lossy;
          r_group    <= r_group + 4'd1;
`ifndef VP_P2B_MAJORITY_BG_EN
          if (r_group == LAST_GROUP) begin
            r_out_bitmap <= w_bitmap;
            r_out_fg     <= w_fg_found ? w_fg : r_bg;
            r_out_bg     <= r_bg;
            r_out_lossy  <= w_lossy;
          end
`endif
        end
`ifdef VP_P2B_MAJORITY_BG_EN
        S_SWAP: begin
          r_out_lossy <= r_lossy;
          if (w_do_swap) begin
            r_out_bitmap <= ~r_bitmap;
            r_out_fg     <= r_bg;
            r_out_bg     <= r_fg;
          end else begin
            r_out_bitmap <= r_bitmap;
            r_out_fg     <= r_fg_found ? r_fg : r_bg;
            r_out_bg     <= r_bg;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
